// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: scan counters, sync, data enable,
// line/frame strobes and a completed-frame counter, all registered with zero lag.
module video_timing_gen #(
  parameter int unsigned WIDTH       = 1920,
  parameter int unsigned HEIGHT      = 1080,
  parameter int unsigned H_SYNC_TIME = 44,
  parameter int unsigned V_SYNC_TIME = 5,
  parameter int unsigned H_F_PORCH   = 88,
  parameter int unsigned V_F_PORCH   = 4,
  parameter int unsigned H_B_PORCH   = 148,
  parameter int unsigned V_B_PORCH   = 36,
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH;
  localparam int unsigned V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH;

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC  = 16'(H_SYNC_TIME);
  localparam logic [15:0] V_SYNC  = 16'(V_SYNC_TIME);
  localparam logic [15:0] H_ACT0  = 16'(H_SYNC_TIME + H_B_PORCH);
  localparam logic [15:0] V_ACT0  = 16'(V_SYNC_TIME + V_B_PORCH);
  localparam logic [15:0] H_ACT1  = 16'(H_SYNC_TIME + H_B_PORCH + WIDTH);
  localparam logic [15:0] V_ACT1  = 16'(V_SYNC_TIME + V_B_PORCH + HEIGHT);

  logic [15:0] h_next;
  logic [15:0] v_next;
  logic        h_wrap;
  logic        hs_act;
  logic        vs_act;
  logic        vde_next;
  logic        frame_wrap;

  always_comb begin
    h_wrap = (x == H_LAST);
    h_next = h_wrap ? '0 : x + 16'd1;
    v_next = y;
    if (h_wrap) begin
      v_next = (y == V_LAST) ? '0 : y + 16'd1;
    end
  end

  // Outputs are decoded from the next position so they land on the same edge
  // as the counters, keeping every output aligned with x/y.
  always_comb begin
    hs_act     = (h_next < H_SYNC);
    vs_act     = (v_next < V_SYNC);
    vde_next   = (h_next >= H_ACT0) && (h_next < H_ACT1) &&
                 (v_next >= V_ACT0) && (v_next < V_ACT1);
    frame_wrap = (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= H_LAST;
      y           <= V_LAST;
      vde         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      x           <= h_next;
      y           <= v_next;
      vde         <= vde_next;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      line_start  <= (h_next == '0);
      frame_start <= frame_wrap;
      frame_cnt   <= frame_cnt + {15'b0, frame_wrap};
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator; sits directly upstream of the pixel generator.
- Produces the raw x/y scan counters, the vde (video data enable) flag and hsync/vsync for the HDMI/DVI encoder.
- Also produces line/frame strobes and a frame counter so downstream sprite/tile logic can update on frame boundaries.
- Defaults give 1920x1080p60 (2200x1125 total) at a 148.5 MHz pixel rate.

Parameters:
- WIDTH, 1920, active pixels per line
- HEIGHT, 1080, active lines per frame
- H_SYNC_TIME, 44, hsync width in pixels
- V_SYNC_TIME, 5, vsync width in lines
- H_F_PORCH, 88, horizontal front porch in pixels
- V_F_PORCH, 4, vertical front porch in lines
- H_B_PORCH, 148, horizontal back porch in pixels
- V_B_PORCH, 36, vertical back porch in lines
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel clock enable; state advances only when 1
- x  out  16  horizontal count, 0..H_TOTAL-1
- y  out  16  vertical count, 0..V_TOTAL-1
- vde  out  1  high inside the active region
- hsync  out  1  horizontal sync at HS_POL level when active
- vsync  out  1  vertical sync at VS_POL level when active
- line_start  out  1  one-enabled-cycle pulse when x becomes 0
- frame_start  out  1  one-enabled-cycle pulse when (x,y) becomes (0,0)
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH (2200).
  - V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH (1125).
  - H_ACT0 = H_SYNC_TIME + H_B_PORCH (192).
  - V_ACT0 = V_SYNC_TIME + V_B_PORCH (41).
- Line order is sync, back porch, active, front porch; the frame uses the same order in lines.
- Reset (async assert, released synchronously to clk by the system reset block):
  - Internal counters load h = H_TOTAL-1, v = V_TOTAL-1, i.e. the last pixel of a frame.
  - Outputs: x = H_TOTAL-1, y = V_TOTAL-1, vde = 0, hsync = ~HS_POL, vsync = ~VS_POL, line_start = 0, frame_start = 0, frame_cnt = 0.
- Counting, on each rising clk with en = 1:
  - h_next = (h == H_TOTAL-1) ? 0 : h+1.
  - On h wrap: v_next = (v == V_TOTAL-1) ? 0 : v+1; otherwise v holds.
- Every output is a register loaded on the same edge as the counters, decoded from (h_next, v_next). Zero lag: x == h and y == v on every cycle.
- Decode:
  - hsync active iff h < H_SYNC_TIME.
  - vsync active iff v < V_SYNC_TIME, for whole lines, changing only at h = 0.
  - vde = (H_ACT0 <= h < H_ACT0+WIDTH) && (V_ACT0 <= v < V_ACT0+HEIGHT).
  - line_start = (h == 0).
  - frame_start = (h == 0 && v == 0).
- frame_cnt increments by 1 on the edge where (h,v) wraps to (0,0), and wraps modulo 2^16.
- First enabled edge after reset moves to (0,0): frame_start = 1, line_start = 1, hsync and vsync active, frame_cnt = 1.
- en = 0:
  - Counters, x, y, vde, hsync, vsync and frame_cnt hold.
  - line_start and frame_start are forced to 0, so each pulse lasts exactly one enabled cycle.
- Reset asserted mid-frame returns immediately (asynchronously) to the reset values; no partial-frame state survives.
- Width rules:
  - Counters are 16 bits; H_TOTAL and V_TOTAL must be ≤ 65535.
  - Comparisons are unsigned.
  - No subtraction is performed, so no underflow is possible.

Test Plan:
- Reset with en = 1 -> during reset x = 2199, y = 1124, vde = 0, hsync = vsync = 0, frame_cnt = 0; first edge after release -> x = 0, y = 0, hsync = 1, vsync = 1, frame_start = 1, line_start = 1, frame_cnt = 1.
- Run one line -> hsync high for x = 0..43 only; line_start high only at x = 0; at x = 2199 then 0, y increments from 0 to 1.
- Run to active region -> vde first high at (x = 192, y = 41), low at x = 2112, last high at (2111, 1120); exactly 1920x1080 vde cycles per frame.
- Full frame -> vsync high for y = 0..4 (5x2200 cycles); at (2199, 1124) -> (0, 0) frame_cnt goes 1 -> 2 and frame_start pulses once.
- Toggle en low for 10 cycles mid-line at x = 500 -> x stays 500, all outputs stable, no strobes; resume at x = 501. Holding en low across x = 0 keeps line_start at 1 for only one enabled cycle.
- Small configuration (WIDTH = 4, HEIGHT = 2, porches/syncs = 1, HS_POL = VS_POL = 0) -> H_TOTAL = 7, V_TOTAL = 5, hsync low only at x = 0; assert rst_n low at (3, 2) -> outputs return to reset values within the same cycle.
